// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer: issues in-order word fetches under a credit limit,
// queues returning instructions for decode and discards stale responses after redirects.
module ifetch_buffer #(
    parameter int              AW       = 30,
    parameter int              DW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RST_ADDR = '0
) (
    input  logic          CLK,
    input  logic          RSTN,
    output logic          IREQ,
    output logic [AW-1:0] IADDR,
    input  logic          IGNT,
    input  logic          IRVALID,
    input  logic [DW-1:0] INSTR,
    input  logic          REDIR,
    input  logic [AW-1:0] REDIR_ADDR,
    output logic          DVALID,
    output logic [DW-1:0] DINSTR,
    output logic [AW-1:0] DADDR,
    input  logic          DREADY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

    logic [AW-1:0] fa;
    logic [AW-1:0] ra;
    logic [CW-1:0] o_cnt;
    logic [CW-1:0] dr_cnt;
    logic [CW-1:0] c_cnt;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic [DW-1:0] instr_mem [DEPTH];
    logic [AW-1:0] addr_mem  [DEPTH];

    logic [CW:0]   in_use;
    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] o_next;

    // Requests in flight plus queued entries bound the queue, so a response always has a slot.
    assign in_use    = {1'b0, o_cnt} + {1'b0, c_cnt};
    assign IREQ      = RSTN & ~REDIR & (in_use < CREDIT);
    assign IADDR     = fa;
    assign req_fire  = IREQ & IGNT;
    assign resp_fire = IRVALID & (o_cnt != '0);
    assign push      = resp_fire & (dr_cnt == '0) & ~REDIR;
    assign DVALID    = (c_cnt != '0);
    assign pop       = DVALID & DREADY;
    assign DINSTR    = DVALID ? instr_mem[rptr] : '0;
    assign DADDR     = DVALID ? addr_mem[rptr]  : '0;

    // NOTE: always_comb assigns a default first so no path leaves o_next unassigned (no latch).
    always_comb begin
        o_next = o_cnt;
        if (req_fire && !resp_fire)
            o_next = o_cnt + CW'(1);
        else if (!req_fire && resp_fire)
            o_next = o_cnt - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fa     <= RST_ADDR;
            ra     <= RST_ADDR;
            o_cnt  <= '0;
            dr_cnt <= '0;
            c_cnt  <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            o_cnt <= o_next;
            if (REDIR) begin
                fa     <= REDIR_ADDR;
                ra     <= REDIR_ADDR;
                c_cnt  <= '0;
                wptr   <= '0;
                rptr   <= '0;
                // Every request still outstanding after this edge belongs to the old stream.
                dr_cnt <= o_cnt - CW'(resp_fire);
            end else begin
                if (req_fire)
                    fa <= fa + AW'(1);
                if (resp_fire && dr_cnt != '0)
                    dr_cnt <= dr_cnt - CW'(1);
                if (push) begin
                    ra   <= ra + AW'(1);
                    wptr <= wptr + PW'(1);
                end
                if (pop)
                    rptr <= rptr + PW'(1);
                if (push && !pop)
                    c_cnt <= c_cnt + CW'(1);
                else if (!push && pop)
                    c_cnt <= c_cnt - CW'(1);
            end
        end
    end

    // NOTE: queue storage has no reset; entries are only visible once c_cnt marks them valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wptr] <= INSTR;
            addr_mem[wptr]  <= ra;
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer: an in-order memory model with random latency
// feeds the DUT, and a queue-based reference predicts fetch and decode outputs.
module tb_ifetch_buffer;

    localparam int            AW       = 8;
    localparam int            DW       = 32;
    localparam int            DEPTH    = 4;
    localparam logic [AW-1:0] RST_ADDR = 8'hFE;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic          IGNT;
    logic          IRVALID;
    logic [DW-1:0] INSTR;
    logic          REDIR;
    logic [AW-1:0] REDIR_ADDR;
    logic          DVALID;
    logic [DW-1:0] DINSTR;
    logic [AW-1:0] DADDR;
    logic          DREADY;

    ifetch_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RST_ADDR(RST_ADDR)) dut (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT),
        .IRVALID(IRVALID), .INSTR(INSTR), .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR),
        .DVALID(DVALID), .DINSTR(DINSTR), .DADDR(DADDR), .DREADY(DREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
        bit            stale;
    } req_t;

    req_t          mem_q[$];   // accepted requests awaiting a response, in order
    logic [AW-1:0] dq[$];      // addresses the decode side should see, in order
    logic [AW-1:0] m_fa;
    int            cyc;
    int            last_due;
    int            checks;
    int            errors;
    bit            resp_real;

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        return (32'(a) * 32'h0101_0101) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input int p_ignt, input int p_dready, input int p_redir,
                        input int lat_max, input int p_spur);
        bit      exp_ireq;
        bit      req_ok;
        bit      pop;
        req_t    r;
        int      lat;
        REDIR      = ($urandom_range(99) < p_redir);
        REDIR_ADDR = AW'($urandom);
        IGNT       = ($urandom_range(99) < p_ignt);
        DREADY     = ($urandom_range(99) < p_dready);
        resp_real  = 1'b0;
        IRVALID    = 1'b0;
        INSTR      = $urandom;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc && $urandom_range(99) < 85) begin
                IRVALID   = 1'b1;
                INSTR     = mem_word(mem_q[0].addr);
                resp_real = 1'b1;
            end
        end else if ($urandom_range(99) < p_spur) begin
            IRVALID = 1'b1;
        end
        #4;
        exp_ireq = !REDIR && (mem_q.size() + dq.size() < DEPTH);
        check("ireq", 64'(IREQ), 64'(exp_ireq));
        check("iaddr", 64'(IADDR), 64'(m_fa));
        check("dvalid", 64'(DVALID), 64'(dq.size() != 0));
        if (dq.size() != 0) begin
            check("daddr", 64'(DADDR), 64'(dq[0]));
            check("dinstr", 64'(DINSTR), 64'(mem_word(dq[0])));
        end
        req_ok = exp_ireq && IGNT;
        pop    = (dq.size() != 0) && DREADY;
        if (pop)
            void'(dq.pop_front());
        if (resp_real) begin
            r = mem_q.pop_front();
            if (!r.stale && !REDIR)
                dq.push_back(r.addr);
        end
        if (REDIR) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            dq.delete();
            m_fa = REDIR_ADDR;
        end
        if (req_ok) begin
            lat      = $urandom_range(lat_max, 1);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
            mem_q.push_back('{addr: m_fa, due: last_due, stale: 1'b0});
            m_fa = m_fa + AW'(1);
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic run(input int n, input int p_ignt, input int p_dready, input int p_redir,
                       input int lat_max, input int p_spur);
        for (int i = 0; i < n; i++)
            step(p_ignt, p_dready, p_redir, lat_max, p_spur);
    endtask

    task automatic apply_reset();
        IGNT = 1'b0; IRVALID = 1'b0; REDIR = 1'b0; DREADY = 1'b0;
        #2 RSTN = 1'b0;
        #1;
        check("rst_ireq", 64'(IREQ), 64'd0);
        check("rst_dvalid", 64'(DVALID), 64'd0);
        check("rst_daddr", 64'(DADDR), 64'd0);
        check("rst_dinstr", 64'(DINSTR), 64'd0);
        check("rst_iaddr", 64'(IADDR), 64'(RST_ADDR));
        mem_q.delete();
        dq.delete();
        m_fa     = RST_ADDR;
        last_due = 0;
        @(posedge CLK);
        @(posedge CLK);
        cyc += 2;
        #1 RSTN = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_due = 0;
        RSTN = 1'b1; INSTR = '0; REDIR_ADDR = '0;
        @(posedge CLK);
        #1;
        apply_reset();
        run(40, 100, 100, 0, 1, 0);     // streaming with wrap from 0xFE
        run(20, 100, 0, 0, 1, 0);       // backpressure fills the queue
        run(20, 100, 100, 0, 1, 0);     // drain and resume
        run(30, 100, 100, 0, 3, 0);     // longer latency, no redirect
        run(300, 70, 60, 8, 4, 30);     // mixed random traffic with redirects
        run(40, 0, 50, 5, 3, 0);        // grant stall with redirects
        run(60, 90, 80, 15, 3, 20);
        apply_reset();                  // reset with traffic in flight
        run(300, 75, 70, 10, 5, 30);
        run(20, 100, 100, 30, 1, 0);    // back-to-back redirects
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
